// File: rtl/video_timing_gen.sv
// Raster timing generator with shadowed run-time config applied only at frame boundaries.
// Outputs registered, one cycle behind the h/v counters; en=0 freezes counters and levels, suppresses pulses.
module video_timing_gen #(
    parameter int CNT_W    = 12,
    parameter int D_H_ACT  = 640,
    parameter int D_H_FP   = 16,
    parameter int D_H_SYNC = 96,
    parameter int D_H_BP   = 48,
    parameter int D_V_ACT  = 480,
    parameter int D_V_FP   = 10,
    parameter int D_V_SYNC = 2,
    parameter int D_V_BP   = 33,
    parameter int D_HS_POL = 0,
    parameter int D_VS_POL = 0
) (
    input  logic             VGA_CLK,
    input  logic             RESET,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_h_act,
    input  logic [CNT_W-1:0] cfg_h_fp,
    input  logic [CNT_W-1:0] cfg_h_sync,
    input  logic [CNT_W-1:0] cfg_h_bp,
    input  logic [CNT_W-1:0] cfg_v_act,
    input  logic [CNT_W-1:0] cfg_v_fp,
    input  logic [CNT_W-1:0] cfg_v_sync,
    input  logic [CNT_W-1:0] cfg_v_bp,
    input  logic             cfg_hs_pol,
    input  logic             cfg_vs_pol,
    output logic             cfg_pending,
    output logic             cfg_err,
    output logic             hs_o,
    output logic             vs_o,
    output logic             de_o,
    output logic [CNT_W-1:0] x_o,
    output logic [CNT_W-1:0] y_o,
    output logic             sof_o,
    output logic             eol_o
);

    localparam int SW = CNT_W + 2;

    typedef struct packed {
        logic [CNT_W-1:0] h_act;
        logic [CNT_W-1:0] h_fp;
        logic [CNT_W-1:0] h_sync;
        logic [CNT_W-1:0] h_bp;
        logic [CNT_W-1:0] v_act;
        logic [CNT_W-1:0] v_fp;
        logic [CNT_W-1:0] v_sync;
        logic [CNT_W-1:0] v_bp;
        logic             hs_pol;
        logic             vs_pol;
    } timing_t;

    localparam timing_t DEF_CFG = '{
        h_act:  CNT_W'(D_H_ACT),
        h_fp:   CNT_W'(D_H_FP),
        h_sync: CNT_W'(D_H_SYNC),
        h_bp:   CNT_W'(D_H_BP),
        v_act:  CNT_W'(D_V_ACT),
        v_fp:   CNT_W'(D_V_FP),
        v_sync: CNT_W'(D_V_SYNC),
        v_bp:   CNT_W'(D_V_BP),
        hs_pol: 1'(D_HS_POL),
        vs_pol: 1'(D_VS_POL)
    };

    localparam logic [SW-1:0] ONE     = SW'(1);
    localparam logic [SW-1:0] CNT_MAX = SW'((1 << CNT_W) - 1);

    timing_t          act_cfg;
    timing_t          shadow_cfg;
    timing_t          new_cfg;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;

    logic [SW-1:0] h_ext, v_ext;
    logic [SW-1:0] ht, vt, new_ht, new_vt;
    logic [SW-1:0] hs_start, hs_end, vs_start, vs_end;
    logic          h_last, v_last, apply;
    logic          cfg_bad;
    logic          de_d, hs_act, vs_act, sof_d, eol_d;

    always_comb begin
        new_cfg = '{
            h_act:  cfg_h_act,
            h_fp:   cfg_h_fp,
            h_sync: cfg_h_sync,
            h_bp:   cfg_h_bp,
            v_act:  cfg_v_act,
            v_fp:   cfg_v_fp,
            v_sync: cfg_v_sync,
            v_bp:   cfg_v_bp,
            hs_pol: cfg_hs_pol,
            vs_pol: cfg_vs_pol
        };
        new_ht = SW'(new_cfg.h_act) + SW'(new_cfg.h_fp) + SW'(new_cfg.h_sync) + SW'(new_cfg.h_bp);
        new_vt = SW'(new_cfg.v_act) + SW'(new_cfg.v_fp) + SW'(new_cfg.v_sync) + SW'(new_cfg.v_bp);
        cfg_bad = (new_cfg.h_act == '0) || (new_cfg.h_fp == '0) ||
                  (new_cfg.h_sync == '0) || (new_cfg.h_bp == '0) ||
                  (new_cfg.v_act == '0) || (new_cfg.v_fp == '0) ||
                  (new_cfg.v_sync == '0) || (new_cfg.v_bp == '0) ||
                  (new_ht > CNT_MAX) || (new_vt > CNT_MAX);
    end

    always_comb begin
        h_ext    = SW'(h);
        v_ext    = SW'(v);
        hs_start = SW'(act_cfg.h_act) + SW'(act_cfg.h_fp);
        hs_end   = hs_start + SW'(act_cfg.h_sync);
        ht       = hs_end + SW'(act_cfg.h_bp);
        vs_start = SW'(act_cfg.v_act) + SW'(act_cfg.v_fp);
        vs_end   = vs_start + SW'(act_cfg.v_sync);
        vt       = vs_end + SW'(act_cfg.v_bp);
        h_last   = (h_ext == ht - ONE);
        v_last   = (v_ext == vt - ONE);
        apply    = en && h_last && v_last && cfg_pending;
        de_d     = (h < act_cfg.h_act) && (v < act_cfg.v_act);
        hs_act   = (h_ext >= hs_start) && (h_ext < hs_end);
        vs_act   = (v_ext >= vs_start) && (v_ext < vs_end);
        sof_d    = de_d && (h == '0) && (v == '0);
        eol_d    = de_d && (h_ext == SW'(act_cfg.h_act) - ONE);
    end

    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            h           <= '0;
            v           <= '0;
            act_cfg     <= DEF_CFG;
            shadow_cfg  <= DEF_CFG;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
            de_o        <= 1'b0;
            sof_o       <= 1'b0;
            eol_o       <= 1'b0;
            x_o         <= '0;
            y_o         <= '0;
            hs_o        <= ~DEF_CFG.hs_pol;
            vs_o        <= ~DEF_CFG.vs_pol;
        end else begin
            cfg_err <= en && cfg_load && cfg_bad;
            sof_o   <= en && sof_d;
            eol_o   <= en && eol_d;
            if (en) begin
                de_o <= de_d;
                hs_o <= hs_act ^ ~act_cfg.hs_pol;
                // VS only moves at line start so it stays aligned to the HS/DE grid.
                if (h == '0) begin
                    vs_o <= vs_act ^ ~act_cfg.vs_pol;
                end
                if (de_d) begin
                    x_o <= h;
                    y_o <= v;
                end
                if (h_last) begin
                    h <= '0;
                    v <= v_last ? '0 : v + CNT_W'(1);
                end else begin
                    h <= h + CNT_W'(1);
                end
            end
            // Apply takes the old shadow; a same-cycle accepted load refills it and keeps pending set.
            if (apply) begin
                act_cfg <= shadow_cfg;
            end
            if (cfg_load && !cfg_bad) begin
                shadow_cfg  <= new_cfg;
                cfg_pending <= 1'b1;
            end else if (apply) begin
                cfg_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: frame-index model checked every cycle, plus literal frame measurements.
module tb_video_timing_gen;

    localparam int CW = 8;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, hp, vp;
    } tcfg_t;

    localparam tcfg_t DEF = '{8, 2, 3, 2, 4, 1, 2, 1, 0, 0};

    logic          VGA_CLK, RESET, en, cfg_load;
    logic [CW-1:0] cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp;
    logic [CW-1:0] cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp;
    logic          cfg_hs_pol, cfg_vs_pol;
    logic          cfg_pending, cfg_err, hs_o, vs_o, de_o, sof_o, eol_o;
    logic [CW-1:0] x_o, y_o;

    video_timing_gen #(
        .CNT_W(CW), .D_H_ACT(8), .D_H_FP(2), .D_H_SYNC(3), .D_H_BP(2),
        .D_V_ACT(4), .D_V_FP(1), .D_V_SYNC(2), .D_V_BP(1), .D_HS_POL(0), .D_VS_POL(0)
    ) dut (
        .VGA_CLK(VGA_CLK), .RESET(RESET), .en(en), .cfg_load(cfg_load),
        .cfg_h_act(cfg_h_act), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
        .cfg_v_act(cfg_v_act), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
        .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
        .cfg_pending(cfg_pending), .cfg_err(cfg_err), .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o),
        .x_o(x_o), .y_o(y_o), .sof_o(sof_o), .eol_o(eol_o)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 0;

    // Model state: position is a flat pixel index into the current frame.
    int    m_idx;
    tcfg_t m_act, m_sh;
    bit    m_pend;
    bit    e_de, e_hs, e_vs, e_sof, e_eol, e_err;
    int    e_x, e_y;

    initial begin
        VGA_CLK = 1'b0;
        forever #5 VGA_CLK = ~VGA_CLK;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    endtask

    function automatic int htot(input tcfg_t c);
        return c.ha + c.hf + c.hs + c.hb;
    endfunction

    function automatic int vtot(input tcfg_t c);
        return c.va + c.vf + c.vs + c.vb;
    endfunction

    initial begin : model
        tcfg_t nc;
        int    ht, vt, h, v;
        bit    bad, fend, hact, vact;
        forever begin
            @(posedge VGA_CLK);
            nc = '{int'(cfg_h_act), int'(cfg_h_fp), int'(cfg_h_sync), int'(cfg_h_bp),
                   int'(cfg_v_act), int'(cfg_v_fp), int'(cfg_v_sync), int'(cfg_v_bp),
                   int'(cfg_hs_pol), int'(cfg_vs_pol)};
            bad = (nc.ha == 0) || (nc.hf == 0) || (nc.hs == 0) || (nc.hb == 0) ||
                  (nc.va == 0) || (nc.vf == 0) || (nc.vs == 0) || (nc.vb == 0) ||
                  (htot(nc) > (1 << CW) - 1) || (vtot(nc) > (1 << CW) - 1);
            if (RESET) begin
                m_idx = 0; m_act = DEF; m_sh = DEF; m_pend = 0;
                e_de = 0; e_sof = 0; e_eol = 0; e_err = 0; e_x = 0; e_y = 0;
                e_hs = (DEF.hp == 0); e_vs = (DEF.vp == 0);
            end else begin
                ht = htot(m_act); vt = vtot(m_act); fend = 0;
                e_err = cfg_load && bad && en;
                e_sof = 0; e_eol = 0;
                if (en) begin
                    h = m_idx % ht; v = m_idx / ht;
                    e_de = (h < m_act.ha) && (v < m_act.va);
                    hact = (h >= m_act.ha + m_act.hf) && (h < m_act.ha + m_act.hf + m_act.hs);
                    e_hs = (m_act.hp != 0) ? hact : !hact;
                    if (h == 0) begin
                        vact = (v >= m_act.va + m_act.vf) && (v < m_act.va + m_act.vf + m_act.vs);
                        e_vs = (m_act.vp != 0) ? vact : !vact;
                    end
                    if (e_de) begin e_x = h; e_y = v; end
                    e_sof = e_de && (m_idx == 0);
                    e_eol = e_de && (h == m_act.ha - 1);
                    m_idx++;
                    if (m_idx == ht * vt) begin m_idx = 0; fend = 1; end
                end
                if (fend && m_pend) begin m_act = m_sh; m_pend = 0; end
                if (cfg_load && !bad) begin m_sh = nc; m_pend = 1; end
            end
        end
    end

    initial begin : compare
        logic [31:0] got_v, exp_v;
        forever begin
            @(negedge VGA_CLK);
            if (chk_on) begin
                got_v = {9'b0, cfg_pending, cfg_err, hs_o, vs_o, de_o, sof_o, eol_o, x_o, y_o};
                exp_v = {9'b0, m_pend, e_err, e_hs, e_vs, e_de, e_sof, e_eol, CW'(e_x), CW'(e_y)};
                check("cycle", got_v, exp_v);
            end
        end
    end

    task automatic drive_cfg(input tcfg_t c);
        cfg_h_act = c.ha[CW-1:0]; cfg_h_fp = c.hf[CW-1:0];
        cfg_h_sync = c.hs[CW-1:0]; cfg_h_bp = c.hb[CW-1:0];
        cfg_v_act = c.va[CW-1:0]; cfg_v_fp = c.vf[CW-1:0];
        cfg_v_sync = c.vs[CW-1:0]; cfg_v_bp = c.vb[CW-1:0];
        cfg_hs_pol = c.hp[0]; cfg_vs_pol = c.vp[0];
    endtask

    task automatic load_cfg(input tcfg_t c);
        drive_cfg(c);
        cfg_load = 1'b1;
        @(negedge VGA_CLK);
        cfg_load = 1'b0;
    endtask

    task automatic wait_idx(input int n);
        int t = 0;
        while (m_idx != n && t < 3000) begin @(negedge VGA_CLK); t++; end
        if (t >= 3000) check("wait_idx_timeout", 32'(t), 0);
    endtask

    // Counts over one sof-to-sof window; hs/vs counted at their active level.
    task automatic measure(input string tag, input int ph, input int pv, input bit tog,
                           input int w_per, input int w_de, input int w_hs, input int w_vs);
        int t = 0, per = 0, nde = 0, nhs = 0, nvs = 0;
        while (!sof_o && t < 3000) begin @(negedge VGA_CLK); t++; end
        if (t >= 3000) check({tag, "_sof_timeout"}, 32'(t), 0);
        do begin
            nde += int'(de_o);
            nhs += int'(hs_o == ph[0]);
            nvs += int'(vs_o == pv[0]);
            if (tog) en = ~en;
            @(negedge VGA_CLK);
            per++;
        end while (!sof_o && per < 3000);
        check({tag, "_period"}, 32'(per), 32'(w_per));
        check({tag, "_de"}, 32'(nde), 32'(w_de));
        check({tag, "_hs"}, 32'(nhs), 32'(w_hs));
        check({tag, "_vs"}, 32'(nvs), 32'(w_vs));
    endtask

    initial begin : stim
        tcfg_t cb, cc, bad1, bad2, big;
        cb   = '{10, 1, 4, 3, 5, 1, 1, 2, 1, 1};
        cc   = '{6, 1, 2, 1, 3, 1, 1, 1, 0, 1};
        bad1 = '{8, 2, 0, 2, 4, 1, 2, 1, 0, 0};
        bad2 = '{250, 2, 2, 2, 4, 1, 2, 1, 0, 0};
        big  = '{250, 1, 2, 2, 1, 1, 1, 1, 0, 0};

        RESET = 1'b1; en = 1'b1; cfg_load = 1'b0;
        drive_cfg(DEF);
        repeat (3) @(negedge VGA_CLK);
        chk_on = 1;
        check("rst_de", 32'(de_o), 0);
        check("rst_hs", 32'(hs_o), 1);
        check("rst_vs", 32'(vs_o), 1);
        check("rst_pend", 32'(cfg_pending), 0);
        RESET = 1'b0;
        @(negedge VGA_CLK);
        check("first_sof", 32'(sof_o), 1);

        measure("def1", 0, 0, 0, 120, 32, 24, 30);
        measure("def2", 0, 0, 0, 120, 32, 24, 30);

        load_cfg(bad1);
        check("rej_sync0_err", 32'(cfg_err), 1);
        check("rej_sync0_pend", 32'(cfg_pending), 0);
        @(negedge VGA_CLK);
        check("rej_err_once", 32'(cfg_err), 0);
        load_cfg(bad2);
        check("rej_ht256_err", 32'(cfg_err), 1);
        check("rej_ht256_pend", 32'(cfg_pending), 0);
        load_cfg(big);
        check("acc_ht255_err", 32'(cfg_err), 0);
        check("acc_ht255_pend", 32'(cfg_pending), 1);

        wait_idx(40);
        load_cfg(cb);
        check("mid_load_pend", 32'(cfg_pending), 1);
        measure("new1", 1, 1, 0, 162, 50, 36, 18);
        check("new_pend_clr", 32'(cfg_pending), 0);

        load_cfg(cc);
        wait_idx(4 * 18 + 5);
        RESET = 1'b1;
        @(negedge VGA_CLK);
        RESET = 1'b0;
        check("mrst_de", 32'(de_o), 0);
        check("mrst_hs", 32'(hs_o), 1);
        check("mrst_vs", 32'(vs_o), 1);
        check("mrst_xy", {16'b0, x_o, y_o}, 0);
        check("mrst_pend", 32'(cfg_pending), 0);
        @(negedge VGA_CLK);
        check("mrst_sof", 32'(sof_o), 1);
        measure("mrst", 0, 0, 0, 120, 32, 24, 30);

        measure("tog", 0, 0, 1, 240, 64, 48, 60);
        en = 1'b1;

        @(negedge VGA_CLK);
        load_cfg(cb);
        wait_idx(119);
        load_cfg(cc);
        check("coinc_pend", 32'(cfg_pending), 1);
        measure("coinc_old", 1, 1, 0, 162, 50, 36, 18);
        measure("coinc_new", 0, 1, 0, 60, 18, 12, 10);
        check("coinc_pend_clr", 32'(cfg_pending), 0);

        repeat (5) @(negedge VGA_CLK);
        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
